siso_shift_ctrl: RTL and testbench

- Sequencer for the team's serial-in/serial-out shift register (DEPTH stages, ports s_in/s_out).
- Accepts a parallel word over a valid/ready handshake and clears the register.
- Paces one bit per DIV clocks into the register's s_in, then flushes it.
- Reassembles the bits emerging on s_out into rx_data and pulses done; used for slow-rate bit streaming and register self-test.

---
 rtl/siso_shift_ctrl.sv | 160 ++++++++++++++++
 tb/tb_siso_shift_ctrl.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/siso_shift_ctrl.sv
// Sequencer for an external DEPTH-stage serial-in/serial-out shift register:
// accepts a word, clears the register, paces one bit per DIV clocks into it,
// flushes it, and reassembles the bits returning on s_out into rx_data.
// Latency: done at cycle 2+DIV*(DEPTH+WIDTH) after accept; start_ready only in IDLE.
// Option: define SISO_SHIFT_CTRL_MSB_FIRST_EN to stream MSB first (default LSB first).
module siso_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int DIV   = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             sr_dout,
  output logic             sr_din,
  output logic             sr_shift_en,
  output logic             sr_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int KW = $clog2(DEPTH + WIDTH + 1);
  localparam int DW = $clog2(DIV + 1);

  localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);
  localparam logic [KW-1:0] K_FIRST_RX = KW'(DEPTH);
  localparam logic [KW-1:0] K_LAST     = KW'(DEPTH + WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [KW-1:0]    tick_cnt;
  logic [WIDTH-1:0] tx_q;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] rx_shadow;
  logic [WIDTH-1:0] rx_shadow_nxt;
  logic             din_q;
  logic             tx_bit;
  logic             tick;

  assign tick = (state == SHIFT) && (div_cnt == DIV_LAST);

  // tx_q is consumed as a shift register, so once every data bit has gone out
  // it is all zeros and the flush ticks naturally drive 0 into the register.
`ifdef SISO_SHIFT_CTRL_MSB_FIRST_EN
  assign tx_bit        = tx_q[WIDTH-1];
  assign tx_shifted    = {tx_q[WIDTH-2:0], 1'b0};
  assign rx_shadow_nxt = {rx_shadow[WIDTH-2:0], sr_dout};
`else
  assign tx_bit        = tx_q[0];
  assign tx_shifted    = {1'b0, tx_q[WIDTH-1:1]};
  assign rx_shadow_nxt = {sr_dout, rx_shadow[WIDTH-1:1]};
`endif

  // sr_din carries the fresh bit during a tick and otherwise holds the last one sent
  assign sr_din = tick ? tx_bit : din_q;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and strobe outputs
  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    busy        = 1'b0;
    sr_clr      = 1'b0;
    sr_shift_en = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        sr_clr    = 1'b1;
        busy      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (tick) begin
          sr_shift_en = 1'b1;
          if (tick_cnt == K_LAST) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath: word latch, divider, tick counter, and receive reassembly.
  // sr_dout is sampled on the same edge that shifts the register, so the value
  // captured is the bit presented before that shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_cnt   <= '0;
      tick_cnt  <= '0;
      tx_q      <= '0;
      rx_shadow <= '0;
      rx_data   <= '0;
      din_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            tx_q <= data_in;
          end
        end
        CLEAR: begin
          div_cnt  <= '0;
          tick_cnt <= '0;
        end
        SHIFT: begin
          if (tick) begin
            div_cnt  <= '0;
            tick_cnt <= tick_cnt + 1'b1;
            din_q    <= tx_bit;
            tx_q     <= tx_shifted;
            if (tick_cnt >= K_FIRST_RX) begin
              rx_shadow <= rx_shadow_nxt;
              if (tick_cnt == K_LAST) begin
                rx_data <= rx_shadow_nxt;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// Bench for siso_shift_ctrl: two instances (DIV=4 and DIV=1), each looped
// through a behavioural DEPTH-stage shift register. Expected sr_din bits and
// rx words are queued at stimulus time and consumed as the DUT produces them.
module tb_siso_shift_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;
  localparam int NTICK = DEPTH + WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             a_sv, a_rdy, a_dout, a_din, a_en, a_clr, a_busy, a_done;
  logic [WIDTH-1:0] a_data, a_rx;
  logic             b_sv, b_rdy, b_dout, b_din, b_en, b_clr, b_busy, b_done;
  logic [WIDTH-1:0] b_data, b_rx;

  siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV_A)) dut_a (
    .clk(clk), .reset(reset), .start_valid(a_sv), .start_ready(a_rdy),
    .data_in(a_data), .sr_dout(a_dout), .sr_din(a_din), .sr_shift_en(a_en),
    .sr_clr(a_clr), .busy(a_busy), .done(a_done), .rx_data(a_rx)
  );

  siso_shift_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV_B)) dut_b (
    .clk(clk), .reset(reset), .start_valid(b_sv), .start_ready(b_rdy),
    .data_in(b_data), .sr_dout(b_dout), .sr_din(b_din), .sr_shift_en(b_en),
    .sr_clr(b_clr), .busy(b_busy), .done(b_done), .rx_data(b_rx)
  );

  // Behavioural shift registers under control of each DUT
  logic [DEPTH-1:0] sr_a = '0;
  logic [DEPTH-1:0] sr_b = '0;
  always @(posedge clk) begin
    if (a_clr) sr_a <= '0;
    else if (a_en) sr_a <= {sr_a[DEPTH-2:0], a_din};
    if (b_clr) sr_b <= '0;
    else if (b_en) sr_b <= {sr_b[DEPTH-2:0], b_din};
  end
  assign a_dout = sr_a[DEPTH-1];
  assign b_dout = sr_b[DEPTH-1];

  int n_tests = 0;
  int n_fail  = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Event logs, stamped with the edge index that precedes the observed cycle
  int               a_tick_t[$];
  logic             a_tick_d[$];
  int               a_done_t[$];
  logic [WIDTH-1:0] a_done_rx[$];
  int               a_busy_t[$];
  int               a_clr_t[$];
  int               b_tick_t[$];
  logic             b_tick_d[$];
  int               b_done_t[$];
  logic [WIDTH-1:0] b_done_rx[$];

  always @(negedge clk) begin
    if (a_en === 1'b1) begin a_tick_t.push_back(edge_cnt); a_tick_d.push_back(a_din); end
    if (a_done === 1'b1) begin a_done_t.push_back(edge_cnt); a_done_rx.push_back(a_rx); end
    if (a_busy === 1'b1) a_busy_t.push_back(edge_cnt);
    if (a_clr === 1'b1) a_clr_t.push_back(edge_cnt);
    if (b_en === 1'b1) begin b_tick_t.push_back(edge_cnt); b_tick_d.push_back(b_din); end
    if (b_done === 1'b1) begin b_done_t.push_back(edge_cnt); b_done_rx.push_back(b_rx); end
  end

  // Scoreboard
  logic             exp_din_q[$];
  logic [WIDTH-1:0] exp_rx_q[$];

  task automatic push_expect(input logic [WIDTH-1:0] w);
    for (int k = 0; k < NTICK; k++) begin
      logic b;
      b = 1'b0;
      if (k < WIDTH) begin
`ifdef SISO_SHIFT_CTRL_MSB_FIRST_EN
        b = w[WIDTH-1-k];
`else
        b = w[k];
`endif
      end
      exp_din_q.push_back(b);
    end
    exp_rx_q.push_back(w);
  endtask

  task automatic clear_logs();
    a_tick_t.delete(); a_tick_d.delete(); a_done_t.delete(); a_done_rx.delete();
    a_busy_t.delete(); a_clr_t.delete();
    b_tick_t.delete(); b_tick_d.delete(); b_done_t.delete(); b_done_rx.delete();
    exp_din_q.delete(); exp_rx_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; a_sv = 1'b1; a_data = 8'hA5; b_sv = 1'b1; b_data = 8'h5A;
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if ({a_rdy, a_busy, a_done, a_din, a_en, a_clr} !== 6'b100000 || a_rx !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_a edge %0d: rdy/busy/done/din/en/clr=%b rx=%h, want 100000 rx=00",
                 i, {a_rdy, a_busy, a_done, a_din, a_en, a_clr}, a_rx);
      end
      n_tests++;
      if ({b_rdy, b_busy, b_done, b_din, b_en, b_clr} !== 6'b100000 || b_rx !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_b edge %0d: rdy/busy/done/din/en/clr=%b rx=%h, want 100000 rx=00",
                 i, {b_rdy, b_busy, b_done, b_din, b_en, b_clr}, b_rx);
      end
    end
    a_sv = 1'b0; b_sv = 1'b0;
    reset = 1'b1;
    step();
    n_tests++;
    if (a_busy !== 1'b0 || a_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b rdy=%b, want 0 1", a_busy, a_rdy);
    end
  endtask

  task automatic test_basic();
    int t0, i;
    logic e;
    logic [WIDTH-1:0] ew;
    clear_logs();
    push_expect(8'hA5);
    a_data = 8'hA5; a_sv = 1'b1; t0 = edge_cnt;
    step();
    a_sv = 1'b0; a_data = 8'h00;
    i = 0;
    while (a_done_t.size() < 1 && i < 200) begin step(); i++; end
    repeat (3) step();
    n_tests++;
    if (a_tick_t.size() != NTICK) begin
      n_fail++; $display("FAIL basic_tick_count: got %0d, want %0d", a_tick_t.size(), NTICK);
    end
    for (int k = 0; k < a_tick_t.size(); k++) begin
      n_tests++;
      if (a_tick_t[k] - t0 != 1 + DIV_A * (k + 1)) begin
        n_fail++; $display("FAIL basic_tick_cycle %0d: got %0d, want %0d", k, a_tick_t[k] - t0, 1 + DIV_A * (k + 1));
      end
      e = (exp_din_q.size() > 0) ? exp_din_q.pop_front() : 1'bx;
      n_tests++;
      if (a_tick_d[k] !== e) begin
        n_fail++; $display("FAIL basic_sr_din tick %0d: got %b, want %b", k, a_tick_d[k], e);
      end
    end
    n_tests++;
    if (a_done_t.size() != 1 || (a_done_t.size() == 1 && a_done_t[0] - t0 != 2 + DIV_A * NTICK)) begin
      n_fail++; $display("FAIL basic_done: count %0d first cycle %0d, want 1 at %0d",
                         a_done_t.size(), (a_done_t.size() > 0) ? a_done_t[0] - t0 : -1, 2 + DIV_A * NTICK);
    end
    ew = exp_rx_q.pop_front();
    n_tests++;
    if (a_done_rx.size() < 1 || a_done_rx[0] !== ew) begin
      n_fail++; $display("FAIL basic_rx_data: got %h, want %h", (a_done_rx.size() > 0) ? a_done_rx[0] : 'x, ew);
    end
    n_tests++;
    if (a_rx !== ew) begin
      n_fail++; $display("FAIL basic_rx_hold: got %h, want %h", a_rx, ew);
    end
    n_tests++;
    if (a_busy_t.size() != 65 || (a_busy_t.size() > 0 && (a_busy_t[0] - t0 != 1 || a_busy_t[$] - t0 != 65))) begin
      n_fail++; $display("FAIL basic_busy: %0d cycles, want 65 spanning cycles 1-65", a_busy_t.size());
    end
    n_tests++;
    if (a_clr_t.size() != 1 || (a_clr_t.size() == 1 && a_clr_t[0] - t0 != 1)) begin
      n_fail++; $display("FAIL basic_clr: %0d pulses, want 1 at cycle 1", a_clr_t.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, i;
    logic e;
    logic [WIDTH-1:0] ew;
    clear_logs();
    push_expect(8'h3C);
    push_expect(8'hFF);
    a_data = 8'h3C; a_sv = 1'b1; t0 = edge_cnt;
    i = 0;
    while (a_done !== 1'b1 && i < 200) begin step(); i++; end
    n_tests++;
    if (a_done !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first_done: timeout, done=%b want 1", a_done);
    end
    a_data = 8'hFF;
    step();
    t1 = edge_cnt;
    step();
    a_sv = 1'b0;
    i = 0;
    while (a_done_t.size() < 2 && i < 200) begin step(); i++; end
    repeat (2) step();
    n_tests++;
    if (a_tick_t.size() != 2 * NTICK) begin
      n_fail++; $display("FAIL b2b_tick_count: got %0d, want %0d", a_tick_t.size(), 2 * NTICK);
    end
    for (int k = 0; k < a_tick_d.size(); k++) begin
      e = (exp_din_q.size() > 0) ? exp_din_q.pop_front() : 1'bx;
      n_tests++;
      if (a_tick_d[k] !== e) begin
        n_fail++; $display("FAIL b2b_sr_din tick %0d: got %b, want %b", k, a_tick_d[k], e);
      end
    end
    n_tests++;
    if (a_done_t.size() != 2) begin
      n_fail++; $display("FAIL b2b_done_count: got %0d, want 2", a_done_t.size());
    end else begin
      n_tests++;
      if (a_done_t[0] - t0 != 66 || a_done_t[1] - t1 != 66) begin
        n_fail++; $display("FAIL b2b_done_cycles: got %0d/%0d, want 66/66", a_done_t[0] - t0, a_done_t[1] - t1);
      end
      n_tests++;
      if (a_clr_t.size() != 2 || a_clr_t[$] - a_done_t[0] != 2) begin
        n_fail++; $display("FAIL b2b_second_accept: clr pulses %0d, want 2 with second right after done", a_clr_t.size());
      end
    end
    for (int k = 0; k < a_done_rx.size(); k++) begin
      ew = (exp_rx_q.size() > 0) ? exp_rx_q.pop_front() : 'x;
      n_tests++;
      if (a_done_rx[k] !== ew) begin
        n_fail++; $display("FAIL b2b_rx_data %0d: got %h, want %h", k, a_done_rx[k], ew);
      end
    end
  endtask

  task automatic test_ignore_busy();
    int t0, i, bad;
    logic [WIDTH-1:0] ew;
    clear_logs();
    push_expect(8'hA5);
    a_data = 8'hA5; a_sv = 1'b1; t0 = edge_cnt;
    step();
    a_sv = 1'b0;
    repeat (9) step();
    a_data = 8'h00; a_sv = 1'b1;
    bad = 0;
    while (edge_cnt - t0 < 60) begin
      if (a_rdy !== 1'b0) bad++;
      step();
    end
    a_sv = 1'b0;
    i = 0;
    while (a_done_t.size() < 1 && i < 200) begin step(); i++; end
    repeat (3) step();
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL ignore_ready: start_ready high in %0d SHIFT cycles, want 0", bad);
    end
    n_tests++;
    if (a_tick_t.size() != NTICK || a_done_t.size() != 1) begin
      n_fail++; $display("FAIL ignore_counts: ticks %0d done %0d, want %0d and 1", a_tick_t.size(), a_done_t.size(), NTICK);
    end
    ew = exp_rx_q.pop_front();
    n_tests++;
    if (a_done_rx.size() < 1 || a_done_rx[0] !== ew) begin
      n_fail++; $display("FAIL ignore_rx_data: got %h, want %h", (a_done_rx.size() > 0) ? a_done_rx[0] : 'x, ew);
    end
    n_tests++;
    if (a_busy !== 1'b0) begin
      n_fail++; $display("FAIL ignore_no_reaccept: busy=%b, want 0", a_busy);
    end
  endtask

  task automatic test_abort();
    int t0, i;
    logic [WIDTH-1:0] ew;
    clear_logs();
    a_data = 8'hA5; a_sv = 1'b1; t0 = edge_cnt;
    step();
    a_sv = 1'b0;
    i = 0;
    while (a_tick_t.size() < 6 && i < 100) begin step(); i++; end
    reset = 1'b0;
    step();
    n_tests++;
    if ({a_rdy, a_busy, a_en, a_done, a_clr} !== 5'b10000 || a_rx !== 8'h00) begin
      n_fail++; $display("FAIL abort_state: rdy/busy/en/done/clr=%b rx=%h, want 10000 rx=00",
                         {a_rdy, a_busy, a_en, a_done, a_clr}, a_rx);
    end
    reset = 1'b1;
    repeat (80) step();
    n_tests++;
    if (a_done_t.size() != 0 || a_tick_t.size() != 6) begin
      n_fail++; $display("FAIL abort_no_done: done %0d ticks %0d, want 0 and 6", a_done_t.size(), a_tick_t.size());
    end
    clear_logs();
    push_expect(8'h81);
    a_data = 8'h81; a_sv = 1'b1; t0 = edge_cnt;
    step();
    a_sv = 1'b0;
    i = 0;
    while (a_done_t.size() < 1 && i < 200) begin step(); i++; end
    step();
    ew = exp_rx_q.pop_front();
    n_tests++;
    if (a_done_rx.size() != 1 || a_done_rx[0] !== ew || a_done_t[0] - t0 != 66) begin
      n_fail++; $display("FAIL abort_recover: done %0d rx %h, want 1 done at cycle 66 rx %h",
                         a_done_t.size(), (a_done_rx.size() > 0) ? a_done_rx[0] : 'x, ew);
    end
  endtask

  task automatic test_div1();
    int t0, i;
    logic e;
    logic [WIDTH-1:0] ew;
    clear_logs();
    push_expect(8'h5A);
    b_data = 8'h5A; b_sv = 1'b1; t0 = edge_cnt;
    step();
    b_sv = 1'b0;
    i = 0;
    while (b_done_t.size() < 1 && i < 100) begin step(); i++; end
    repeat (2) step();
    n_tests++;
    if (b_tick_t.size() != NTICK) begin
      n_fail++; $display("FAIL div1_tick_count: got %0d, want %0d", b_tick_t.size(), NTICK);
    end
    for (int k = 0; k < b_tick_t.size(); k++) begin
      n_tests++;
      if (b_tick_t[k] - t0 != 2 + k) begin
        n_fail++; $display("FAIL div1_tick_cycle %0d: got %0d, want %0d", k, b_tick_t[k] - t0, 2 + k);
      end
      e = (exp_din_q.size() > 0) ? exp_din_q.pop_front() : 1'bx;
      n_tests++;
      if (b_tick_d[k] !== e) begin
        n_fail++; $display("FAIL div1_sr_din tick %0d: got %b, want %b", k, b_tick_d[k], e);
      end
    end
    ew = exp_rx_q.pop_front();
    n_tests++;
    if (b_done_t.size() != 1 || b_done_t[0] - t0 != 18 || b_done_rx[0] !== ew) begin
      n_fail++; $display("FAIL div1_done: count %0d rx %h, want 1 at cycle 18 rx %h",
                         b_done_t.size(), (b_done_rx.size() > 0) ? b_done_rx[0] : 'x, ew);
    end
  endtask

  initial begin
    reset = 1'b0;
    a_sv = 1'b0; a_data = '0;
    b_sv = 1'b0; b_data = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
